// File: rtl/id_ex_register.sv
// ID/EX pipeline register: latches decoded control, operands and indices.
// Handles hold, flush and (with IDEX_HAZARD_DETECT_EN) load-use bubbles.
//
// Ports:
//   clk_i, rst_i (sync, active-high), stall_i, flush_i
//   decoded control in : RegWrite_i MemtoReg_i MemRead_i MemWrite_i
//                        ALUSrc_i RegDst_i ALUOp_i[1:0]
//   operands in        : data1_i data2_i imm_i [DATA_W]
//   indices in         : Rs_i Rt_i Rd_i [REG_W]
//   registered outputs : *_o counterparts, RegisterRs/Rt/Rd_o, valid_o
//   PCWrite_o, IFIDWrite_o : upstream enables, low on a load-use hazard
//
// Macro IDEX_HAZARD_DETECT_EN enables the load-use detector and bubble
// path; without it PCWrite_o/IFIDWrite_o are tied high.

module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_W-1:0]  Rs_i,
  input  logic [REG_W-1:0]  Rt_i,
  input  logic [REG_W-1:0]  Rd_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              RegDst_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_W-1:0]  RegisterRs_o,
  output logic [REG_W-1:0]  RegisterRt_o,
  output logic [REG_W-1:0]  RegisterRd_o,
  output logic              valid_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o
);

  logic hazard;

`ifdef IDEX_HAZARD_DETECT_EN
  logic rtNonZero;
  logic rtMatch;

  // A load in EX whose target is read by the instruction in ID.
  // $zero is never a real dependency.
  assign rtNonZero = (RegisterRt_o != '0);
  assign rtMatch   = (RegisterRt_o == Rs_i) | (RegisterRt_o == Rt_i);
  assign hazard    = MemRead_o & rtNonZero & rtMatch;

  // Freeze fetch/decode so the dependent instruction re-enters next cycle.
  assign PCWrite_o   = ~hazard;
  assign IFIDWrite_o = ~hazard;
`else
  assign hazard      = 1'b0;
  assign PCWrite_o   = 1'b1;
  assign IFIDWrite_o = 1'b1;
`endif

  logic clearAll;
  logic bubble;
  logic load;

  assign clearAll = rst_i | flush_i;
  assign bubble   = ~clearAll & ~stall_i & hazard;
  assign load     = ~clearAll & ~stall_i & ~hazard;

  // Control bits and valid: zeroed by reset/flush/bubble.
  always_ff @(posedge clk_i) begin
    if (clearAll || bubble) begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUSrc_o   <= 1'b0;
      RegDst_o   <= 1'b0;
      ALUOp_o    <= 2'b00;
      valid_o    <= 1'b0;
    end else if (load) begin
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      ALUSrc_o   <= ALUSrc_i;
      RegDst_o   <= RegDst_i;
      ALUOp_o    <= ALUOp_i;
      valid_o    <= 1'b1;
    end
  end

  // Operands and Rs/Rt: a bubble loads them anyway (don't-care payload),
  // which keeps the enable logic to reset/flush vs. not-stalled.
  always_ff @(posedge clk_i) begin
    if (clearAll) begin
      data1_o      <= '0;
      data2_o      <= '0;
      imm_o        <= '0;
      RegisterRs_o <= '0;
      RegisterRt_o <= '0;
    end else if (!stall_i) begin
      data1_o      <= data1_i;
      data2_o      <= data2_i;
      imm_o        <= imm_i;
      RegisterRs_o <= Rs_i;
      RegisterRt_o <= Rt_i;
    end
  end

  // Rd is cleared on a bubble so forwarding never sees a phantom writer.
  always_ff @(posedge clk_i) begin
    if (clearAll || bubble) begin
      RegisterRd_o <= '0;
    end else if (load) begin
      RegisterRd_o <= Rd_i;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: reference model plus directed vectors.
// Follows IDEX_HAZARD_DETECT_EN the same way the design does.

module tb_id_ex_register;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mr;
    logic        mw;
    logic        as;
    logic        rd;
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] im;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rdi;
  } instT;

  typedef struct packed {
    instT in;
    logic v;
    logic dc;
  } exT;

  logic clk = 1'b0;
  logic rst, stall, flush;
  instT inp;

  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic        ALUSrc_o, RegDst_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] data1_o, data2_o, imm_o;
  logic [4:0]  RegisterRs_o, RegisterRt_o, RegisterRd_o;
  logic        valid_o, PCWrite_o, IFIDWrite_o;

  int nVec = 0;
  int nErr = 0;

  exT   mdl;
  logic expPc;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_W(32), .REG_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .RegWrite_i  (inp.rw),
    .MemtoReg_i  (inp.mtr),
    .MemRead_i   (inp.mr),
    .MemWrite_i  (inp.mw),
    .ALUSrc_i    (inp.as),
    .RegDst_i    (inp.rd),
    .ALUOp_i     (inp.op),
    .data1_i     (inp.d1),
    .data2_i     (inp.d2),
    .imm_i       (inp.im),
    .Rs_i        (inp.rs),
    .Rt_i        (inp.rt),
    .Rd_i        (inp.rdi),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .ALUSrc_o    (ALUSrc_o),
    .RegDst_o    (RegDst_o),
    .ALUOp_o     (ALUOp_o),
    .data1_o     (data1_o),
    .data2_o     (data2_o),
    .imm_o       (imm_o),
    .RegisterRs_o(RegisterRs_o),
    .RegisterRt_o(RegisterRt_o),
    .RegisterRd_o(RegisterRd_o),
    .valid_o     (valid_o),
    .PCWrite_o   (PCWrite_o),
    .IFIDWrite_o (IFIDWrite_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Is the instruction in ID blocked by a load sitting in EX?
  function automatic logic loadUse(exT ex, instT id);
`ifdef IDEX_HAZARD_DETECT_EN
    return ex.in.mr && ex.in.rt != 0 && (ex.in.rt == id.rs || ex.in.rt == id.rt);
`else
    return 1'b0;
`endif
  endfunction

  // What EX must hold after an edge, from the priority rules.
  function automatic exT nextEx(exT cur, instT id, logic r, logic f,
                                logic s);
    exT n;
    n = '0;
    if (r || f) begin
      n = '0;
    end else if (s) begin
      n = cur;
    end else if (loadUse(cur, id)) begin
      n.in = '0;
      n.in.d1 = id.d1;
      n.in.d2 = id.d2;
      n.in.im = id.im;
      n.in.rs = id.rs;
      n.in.rt = id.rt;
      n.dc = 1'b1;
    end else begin
      n.in = id;
      n.v = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) mdl = nextEx(mdl, inp, rst, flush, stall);

  // Every negedge: all outputs against the model.
  always @(negedge clk) begin
    expPc = !loadUse(mdl, inp);
    chk("PCWrite", PCWrite_o, expPc);
    chk("IFIDWrite", IFIDWrite_o, expPc);
    chk("RegWrite", RegWrite_o, mdl.in.rw);
    chk("MemtoReg", MemtoReg_o, mdl.in.mtr);
    chk("MemRead", MemRead_o, mdl.in.mr);
    chk("MemWrite", MemWrite_o, mdl.in.mw);
    chk("ALUSrc", ALUSrc_o, mdl.in.as);
    chk("RegDst", RegDst_o, mdl.in.rd);
    chk("ALUOp", ALUOp_o, mdl.in.op);
    chk("Rd", RegisterRd_o, mdl.in.rdi);
    chk("valid", valid_o, mdl.v);
    if (!mdl.dc) begin
      chk("data1", data1_o, mdl.in.d1);
      chk("data2", data2_o, mdl.in.d2);
      chk("imm", imm_o, mdl.in.im);
      chk("Rs", RegisterRs_o, mdl.in.rs);
      chk("Rt", RegisterRt_o, mdl.in.rt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    inp = '0;
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic loadOp(input logic [4:0] rt);
    idle();
    inp.mr = 1'b1;
    inp.rw = 1'b1;
    inp.mtr = 1'b1;
    inp.as = 1'b1;
    inp.rs = 5'd3;
    inp.rt = rt;
    inp.rdi = 5'd0;
    inp.im = 32'h10;
  endtask

  task automatic userOp(input logic [4:0] rs, input logic [4:0] rt);
    idle();
    inp.rw = 1'b1;
    inp.op = 2'b10;
    inp.rd = 1'b1;
    inp.rs = rs;
    inp.rt = rt;
    inp.rdi = 5'd6;
    inp.d1 = 32'h55;
    inp.d2 = 32'h66;
  endtask

  logic hzOn;

  initial begin
`ifdef IDEX_HAZARD_DETECT_EN
    hzOn = 1'b1;
`else
    hzOn = 1'b0;
`endif
    mdl = '0;
    inp = '1;
    rst = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    chk("rst RegWrite", RegWrite_o, 0);
    chk("rst data1", data1_o, 0);
    chk("rst valid", valid_o, 0);
    chk("rst PCWrite", PCWrite_o, 1);

    idle();
    inp.rw = 1'b1;
    inp.op = 2'b10;
    inp.d1 = 32'h1234;
    inp.rdi = 5'd5;
    tick();
    chk("load RegWrite", RegWrite_o, 1);
    chk("load ALUOp", ALUOp_o, 2);
    chk("load data1", data1_o, 32'h1234);
    chk("load Rd", RegisterRd_o, 5);
    chk("load valid", valid_o, 1);

    loadOp(5'd2);
    tick();
    userOp(5'd2, 5'd4);
    #1;
    chk("lu PCWrite", PCWrite_o, !hzOn);
    chk("lu IFIDWrite", IFIDWrite_o, !hzOn);
    tick();
    chk("lu MemRead", MemRead_o, 0);
    chk("lu RegWrite", RegWrite_o, !hzOn);
    chk("lu valid", valid_o, !hzOn);
    chk("lu PCWrite after", PCWrite_o, 1);
    tick();
    chk("lu reentry valid", valid_o, 1);
    chk("lu reentry Rd", RegisterRd_o, 6);

    loadOp(5'd0);
    tick();
    userOp(5'd0, 5'd0);
    #1;
    chk("r0 PCWrite", PCWrite_o, 1);
    tick();
    chk("r0 valid", valid_o, 1);

    idle();
    inp.d2 = 32'hCAFE;
    inp.rw = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      inp.d2 = $urandom;
      inp.rdi = 5'($urandom);
      inp.rw = 1'b0;
      stall = 1'b1;
      tick();
      chk("stall data2", data2_o, 32'hCAFE);
      chk("stall valid", valid_o, 1);
    end

    flush = 1'b1;
    tick();
    chk("flush valid", valid_o, 0);
    chk("flush RegWrite", RegWrite_o, 0);
    chk("flush Rd", RegisterRd_o, 0);
    chk("flush Rt", RegisterRt_o, 0);

    loadOp(5'd7);
    tick();
    userOp(5'd7, 5'd1);
    stall = 1'b1;
    tick();
    tick();
    #1;
    chk("stall+hz PCWrite", PCWrite_o, !hzOn);
    stall = 1'b0;
    tick();
    tick();

    loadOp(5'd7);
    tick();
    userOp(5'd7, 5'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst mid PCWrite", PCWrite_o, 1);
    tick();

    loadOp(5'd8);
    tick();
    userOp(5'd1, 5'd8);
    flush = 1'b1;
    #1;
    chk("flush+hz PCWrite", PCWrite_o, !hzOn);
    tick();
    chk("flush+hz valid", valid_o, 0);

    loadOp(5'd9);
    tick();
    loadOp(5'd10);
    inp.rs = 5'd1;
    tick();
    userOp(5'd10, 5'd9);
    tick();
    tick();
    chk("b2b valid", valid_o, 1);

    for (int k = 0; k < 60; k++) begin
      if (!loadUse(mdl, inp) || k == 0) begin
        inp.rw = 1'($urandom);
        inp.mtr = 1'($urandom);
        inp.mr = 1'($urandom);
        inp.mw = 1'($urandom);
        inp.as = 1'($urandom);
        inp.rd = 1'($urandom);
        inp.op = 2'($urandom);
        inp.d1 = $urandom;
        inp.d2 = $urandom;
        inp.im = $urandom;
        inp.rs = 5'($urandom_range(0, 3));
        inp.rt = 5'($urandom_range(0, 3));
        inp.rdi = 5'($urandom);
      end
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 29) == 0);
      tick();
    end

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register for the 5-stage MIPS core, sitting between the decode stage and the EX stage. It latches decoded control, register-file operands, the immediate and the Rs/Rt/Rd indices each cycle. It supplies these to the ALU operand muxes and the forwarding unit (`IDEX_RegisterRs`/`IDEX_RegisterRt`). It also handles hold (stall), flush, and, optionally, load-use hazard detection with bubble insertion.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register index width

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `stall_i` in 1: external hold; all state retains its value.
- `flush_i` in 1: squash the instruction entering EX (branch taken / jump).
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`, `ALUSrc_i`, `RegDst_i` in 1 each: decoded control.
- `ALUOp_i` in 2: ALU operation class.
- `data1_i`, `data2_i` in DATA_W: register-file read data (Rs, Rt).
- `imm_i` in DATA_W: sign-extended immediate.
- `Rs_i`, `Rt_i`, `Rd_i` in REG_W: decode-stage register indices.
- `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o`, `ALUSrc_o`, `RegDst_o` out 1 each: registered control.
- `ALUOp_o` out 2: registered ALU op.
- `data1_o`, `data2_o`, `imm_o` out DATA_W: registered operands.
- `RegisterRs_o`, `RegisterRt_o`, `RegisterRd_o` out REG_W: registered indices.
- `valid_o` out 1: EX holds a real instruction (not a bubble or flush).
- `PCWrite_o`, `IFIDWrite_o` out 1 each: enables to the PC and IF/ID; only with `IDEX_HAZARD_DETECT_EN`, otherwise tied 1.

## Operation
- Rising-edge update priority: `rst_i` > `flush_i` > `stall_i` > hazard bubble > normal load.
- **Reset:** every output register becomes 0. `valid_o` = 0.
- **Flush:** all control outputs, `valid_o` and all three index outputs become 0. Data outputs become 0.
- **Stall:** every register holds its value, including `valid_o`.
- **Bubble** (load-use hazard, with macro enabled only):
  - control outputs, `valid_o` and `RegisterRd_o` become 0;
  - data and Rs/Rt fields load normally; their values are don't-care.
- **Normal load:** every `*_i` is captured into its `*_o`. `valid_o` = 1.
- **Load-use hazard:** `hazard = MemRead_o & (RegisterRt_o != 0) & ((RegisterRt_o == Rs_i) | (RegisterRt_o == Rt_i))`.
- When `hazard` = 1, `PCWrite_o` = `IFIDWrite_o` = 0 in the same cycle. The stalled instruction remains in ID and re-enters on the following cycle.
- A bubble clears `MemRead_o`, so the hazard self-clears after exactly one bubble cycle.
- Register 0 never raises a hazard.

## Timing
- Register outputs: 1-cycle latency, input at edge N appears at `*_o` after edge N.
- `PCWrite_o`, `IFIDWrite_o`: combinational from current `*_o` state and ID inputs, settle within the cycle.
- `stall_i` and `hazard` both high: hold wins, and `PCWrite_o`/`IFIDWrite_o` stay 0 while `hazard` persists.
- `flush_i` and `hazard` both high: flush wins, and `PCWrite_o`/`IFIDWrite_o` remain governed by `hazard`. The upstream flush logic overrides the PC.
- `rst_i` asserted mid-bubble or mid-stall: next edge gives the all-zero state, and `PCWrite_o`/`IFIDWrite_o` are 1 after reset.
- Back-to-back loads with a dependent third instruction: at most one bubble per dependent pair.

## Configuration
- `IDEX_HAZARD_DETECT_EN` defined:
  - load-use detector and bubble path present;
  - `PCWrite_o`/`IFIDWrite_o` driven as above.
- Undefined:
  - no detector and no bubble path;
  - `PCWrite_o` = `IFIDWrite_o` = 1 constant;
  - load-use handling is the responsibility of an external hazard unit, which drives `flush_i`/`stall_i`.

## Test plan
- **Reset:** assert `rst_i` 2 cycles with all inputs 1 → every output 0, `PCWrite_o` = 1.
- **Normal load:** `RegWrite_i`=1, `ALUOp_i`=2'b10, `data1_i`=32'h1234, `Rd_i`=5 → next cycle `RegWrite_o`=1, `ALUOp_o`=2'b10, `data1_o`=32'h1234, `RegisterRd_o`=5, `valid_o`=1.
- **Load-use** (macro on): cycle 0 load `MemRead_i`=1, `Rt_i`=2. Cycle 1 `Rs_i`=2 → `PCWrite_o`=`IFIDWrite_o`=0 in cycle 1. After edge, `MemRead_o`=0, `RegWrite_o`=0, `valid_o`=0. Cycle 2 `PCWrite_o`=1. Repeat with `Rt_i`=0 → no stall.
- **Stall hold:** load `data2_i`=32'hCAFE, then `stall_i`=1 for 3 cycles with changing inputs → `data2_o` remains 32'hCAFE and `valid_o` unchanged.
- **Flush vs stall:** `flush_i`=`stall_i`=1 with valid contents → next cycle all control, indices and `valid_o` = 0.
- **Macro off:** same stimulus as load-use → `PCWrite_o`=1 throughout, and the dependent instruction loads with `valid_o`=1.
